// File: rtl/uart_pkg.sv
// UART receiver shared definitions.
// Frame defaults, clock constant, FSM state type.
package uart_pkg;

  localparam int CLK_FREQ       = 100_000_000;
  localparam int DATA_BITS_DEF  = 8;
  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running oversample tick generator.
// One tick per count_lim cycles; 0 or 1 ticks every cycle.
module baud_tick_gen (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic [11:0] count_lim,
  output logic        tick
);

  logic [11:0] cnt;
  logic        hit;

  // >= keeps a lowered limit from wrapping the counter
  assign hit = (count_lim <= 12'd1) ||
               (cnt >= count_lim - 12'd1);

  assign tick = hit;

  // Count up to the terminal value, then restart
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      cnt <= '0;
    end else if (hit) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 12'd1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver, LSB first.
// Mid-bit sampling, frame error and break handling.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 CLK100MHZ,
  input  logic                 reset,
  input  logic [11:0]          count_lim,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int OS_W  = $clog2(OVERSAMPLE) + 1;
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  localparam logic [OS_W-1:0] OS_MID =
    OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] OS_END =
    OS_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_END =
    BIT_W'(DATA_BITS - 1);

  rx_state_t            state;
  logic [1:0]           sync;
  logic                 rx_s;
  logic                 rx_d;
  logic                 fall;
  logic                 tick;
  logic [OS_W-1:0]      os_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;

  baud_tick_gen u_tick (
    .CLK100MHZ (CLK100MHZ),
    .reset     (reset),
    .count_lim (count_lim),
    .tick      (tick)
  );

  assign rx_s = sync[1];
  assign fall = rx_d & ~rx_s;
  assign busy = (state != IDLE);

  // Two-flop synchronizer plus edge-detect history
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      sync <= 2'b11;
      rx_d <= 1'b1;
    end else begin
      sync <= {sync[0], rx};
      rx_d <= rx_s;
    end
  end

  // Frame FSM with registered strobes and data
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state     <= IDLE;
      os_cnt    <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            state  <= START;
            os_cnt <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (os_cnt == OS_MID) begin
              os_cnt  <= '0;
              bit_cnt <= '0;
              state   <= rx_s ? IDLE : DATA;
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (os_cnt == OS_END) begin
              os_cnt <= '0;
              shreg  <= {rx_s,
                         shreg[DATA_BITS-1:1]};
              if (bit_cnt == BIT_END) begin
                bit_cnt <= '0;
                state   <= STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (os_cnt == OS_END) begin
              os_cnt <= '0;
              if (rx_s) begin
                data  <= shreg;
                valid <= 1'b1;
                state <= IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= BREAK;
              end
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
        end
        BREAK: begin
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx.
// Per-scenario tasks with inline comparisons.
module tb_uart_rx;

  logic        CLK100MHZ = 1'b0;
  logic        reset     = 1'b1;
  logic        rx        = 1'b1;
  logic [11:0] count_lim = 12'd54;
  logic [7:0]  data;
  logic        valid;
  logic        frame_err;
  logic        busy;

  int cmp = 0;
  int err = 0;
  int vcount = 0;
  int fcount = 0;
  int both = 0;
  int bit_cyc = 864;
  logic [7:0] rxq[$];

  always #5 CLK100MHZ = ~CLK100MHZ;

  uart_rx #(
    .DATA_BITS  (8),
    .OVERSAMPLE (16)
  ) dut (
    .CLK100MHZ (CLK100MHZ),
    .reset     (reset),
    .count_lim (count_lim),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always @(negedge CLK100MHZ) begin
    if (valid) begin
      vcount <= vcount + 1;
      rxq.push_back(data);
    end
    if (frame_err) fcount <= fcount + 1;
    if (valid && frame_err) both <= both + 1;
  end

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge CLK100MHZ);
  endtask

  task automatic send(input logic [7:0] b,
                      input logic stop);
    hold(1'b0, bit_cyc);
    for (int i = 0; i < 8; i++) hold(b[i], bit_cyc);
    hold(stop, bit_cyc);
  endtask

  function automatic logic [7:0] qat(input int k);
    if (rxq.size() > k) return rxq[k];
    return 8'hxx;
  endfunction

  task automatic test_reset();
    #1;
    cmp++;
    if (data !== 8'h00) begin
      err++;
      $display("FAIL rst_data got %h want 00", data);
    end
    cmp++;
    if (valid !== 1'b0) begin
      err++;
      $display("FAIL rst_valid got %b want 0", valid);
    end
    cmp++;
    if (frame_err !== 1'b0) begin
      err++;
      $display("FAIL rst_ferr got %b want 0", frame_err);
    end
    cmp++;
    if (busy !== 1'b0) begin
      err++;
      $display("FAIL rst_busy got %b want 0", busy);
    end
    reset = 1'b0;
    hold(1'b1, 20);
  endtask

  task automatic test_frame();
    int v0, f0, q0;
    v0 = vcount; f0 = fcount; q0 = rxq.size();
    send(8'hA5, 1'b1);
    hold(1'b1, 100);
    #1;
    cmp++;
    if (vcount - v0 !== 1) begin
      err++;
      $display("FAIL a5_valid got %0d want 1",
               vcount - v0);
    end
    cmp++;
    if (fcount - f0 !== 0) begin
      err++;
      $display("FAIL a5_ferr got %0d want 0",
               fcount - f0);
    end
    cmp++;
    if (qat(q0) !== 8'hA5) begin
      err++;
      $display("FAIL a5_data got %h want a5", qat(q0));
    end
    cmp++;
    if (data !== 8'hA5) begin
      err++;
      $display("FAIL a5_hold got %h want a5", data);
    end
  endtask

  task automatic test_glitch();
    int v0, f0;
    v0 = vcount; f0 = fcount;
    hold(1'b0, 100);
    #1;
    cmp++;
    if (busy !== 1'b1) begin
      err++;
      $display("FAIL gl_busy_on got %b want 1", busy);
    end
    hold(1'b0, 100);
    hold(1'b1, 1000);
    #1;
    cmp++;
    if (busy !== 1'b0) begin
      err++;
      $display("FAIL gl_busy_off got %b want 0", busy);
    end
    cmp++;
    if ((vcount - v0) + (fcount - f0) !== 0) begin
      err++;
      $display("FAIL gl_pulses got %0d want 0",
               (vcount - v0) + (fcount - f0));
    end
  endtask

  task automatic test_frame_err();
    int v0, f0;
    logic [7:0] b;
    b = 8'h3C;
    v0 = vcount; f0 = fcount;
    hold(1'b0, bit_cyc);
    for (int i = 0; i < 8; i++) hold(b[i], bit_cyc);
    hold(1'b0, bit_cyc + 5000);
    #1;
    cmp++;
    if (fcount - f0 !== 1) begin
      err++;
      $display("FAIL fe_count got %0d want 1",
               fcount - f0);
    end
    cmp++;
    if (vcount - v0 !== 0) begin
      err++;
      $display("FAIL fe_valid got %0d want 0",
               vcount - v0);
    end
    cmp++;
    if (data !== 8'hA5) begin
      err++;
      $display("FAIL fe_data got %h want a5", data);
    end
    cmp++;
    if (busy !== 1'b1) begin
      err++;
      $display("FAIL fe_busy_brk got %b want 1", busy);
    end
    hold(1'b1, 20);
    #1;
    cmp++;
    if (busy !== 1'b0) begin
      err++;
      $display("FAIL fe_busy_end got %b want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int v0, f0, q0;
    v0 = vcount; f0 = fcount; q0 = rxq.size();
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    send(8'h55, 1'b1);
    hold(1'b1, 100);
    #1;
    cmp++;
    if (vcount - v0 !== 3) begin
      err++;
      $display("FAIL b2b_count got %0d want 3",
               vcount - v0);
    end
    cmp++;
    if (fcount - f0 !== 0) begin
      err++;
      $display("FAIL b2b_ferr got %0d want 0",
               fcount - f0);
    end
    cmp++;
    if (qat(q0) !== 8'h00) begin
      err++;
      $display("FAIL b2b_d0 got %h want 00", qat(q0));
    end
    cmp++;
    if (qat(q0 + 1) !== 8'hFF) begin
      err++;
      $display("FAIL b2b_d1 got %h want ff",
               qat(q0 + 1));
    end
    cmp++;
    if (qat(q0 + 2) !== 8'h55) begin
      err++;
      $display("FAIL b2b_d2 got %h want 55",
               qat(q0 + 2));
    end
  endtask

  task automatic test_reset_abort();
    int v0, f0;
    logic [7:0] b;
    b = 8'h81;
    v0 = vcount; f0 = fcount;
    hold(1'b0, bit_cyc);
    for (int i = 0; i < 4; i++) hold(b[i], bit_cyc);
    hold(b[4], bit_cyc / 2);
    reset = 1'b1;
    hold(1'b1, 4);
    #1;
    cmp++;
    if (busy !== 1'b0) begin
      err++;
      $display("FAIL ra_busy got %b want 0", busy);
    end
    cmp++;
    if (data !== 8'h00) begin
      err++;
      $display("FAIL ra_data got %h want 00", data);
    end
    reset = 1'b0;
    hold(1'b1, 2000);
    #1;
    cmp++;
    if ((vcount - v0) + (fcount - f0) !== 0) begin
      err++;
      $display("FAIL ra_pulses got %0d want 0",
               (vcount - v0) + (fcount - f0));
    end
    send(8'h7E, 1'b1);
    hold(1'b1, 100);
    #1;
    cmp++;
    if (vcount - v0 !== 1) begin
      err++;
      $display("FAIL ra_valid got %0d want 1",
               vcount - v0);
    end
    cmp++;
    if (data !== 8'h7E) begin
      err++;
      $display("FAIL ra_data7e got %h want 7e", data);
    end
  endtask

  task automatic test_fast();
    int v0;
    bit_cyc = 16;
    for (int lim = 0; lim < 2; lim++) begin
      count_lim = 12'(lim);
      hold(1'b1, 20);
      v0 = vcount;
      send(8'hC3, 1'b1);
      hold(1'b1, 20);
      #1;
      cmp++;
      if (vcount - v0 !== 1) begin
        err++;
        $display("FAIL fast%0d_valid got %0d want 1",
                 lim, vcount - v0);
      end
      cmp++;
      if (data !== 8'hC3) begin
        err++;
        $display("FAIL fast%0d_data got %h want c3",
                 lim, data);
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge CLK100MHZ);
    test_reset();
    test_frame();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_abort();
    test_fast();
    #1;
    cmp++;
    if (both !== 0) begin
      err++;
      $display("FAIL excl got %0d want 0", both);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp, err);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame (LSB first).
REQ-002 Parameter OVERSAMPLE, default 16, oversample ticks per bit period.
REQ-003 CLK100MHZ  input  1  system clock, 100 MHz; the only clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 count_lim  input  12  CLK100MHZ cycles per oversample tick (100e6 / (OVERSAMPLE*baud)).
REQ-006 rx  input  1  asynchronous serial line, idle high.
REQ-007 data  output  DATA_BITS  last received byte; holds until the next valid frame.
REQ-008 valid  output  1  one-cycle pulse, data updated and good.
REQ-009 frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-010 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-011 rx SHALL pass through a 2-FF synchronizer; all decisions use the synchronized value (2-cycle input latency).
REQ-012 Tick generator SHALL count 0..count_lim-1 and pulse tick for one cycle on the terminal count; count_lim of 0 or 1 SHALL produce a tick every cycle.
REQ-013 A count_lim change SHALL take effect at the next counter compare, with no reset of the counter and no glitch tick.
REQ-014 FSM states: IDLE, START, DATA, STOP, BREAK.
REQ-015 IDLE: a synchronized falling edge of rx -> START, with the oversample counter cleared to 0.
REQ-016 START: at oversample count OVERSAMPLE/2-1 (mid-bit), rx low -> DATA with counter cleared; rx high -> IDLE (false start, no outputs).
REQ-017 DATA: sample rx every OVERSAMPLE ticks at mid-bit and shift it in LSB first; after DATA_BITS samples -> STOP.
REQ-018 STOP: at the mid-bit sample, rx high -> load data and pulse valid the next cycle, then -> IDLE.
REQ-019 STOP: at the mid-bit sample, rx low -> pulse frame_err the next cycle, leave data unchanged, then -> BREAK.
REQ-020 BREAK: remain until synchronized rx is high, then -> IDLE; falling edges SHALL be ignored in BREAK.
REQ-021 valid and frame_err SHALL never assert in the same cycle.
REQ-022 A new start edge SHALL be accepted in the first IDLE cycle after STOP (back-to-back frames).
REQ-023 The shift register SHALL be internal; data SHALL change only in the cycle valid asserts.
REQ-024 Oversample and bit counters SHALL be wide enough for OVERSAMPLE and DATA_BITS, with no wrap-around inside a frame.

Reset
REQ-025 When reset is high at a CLK100MHZ edge: state=IDLE, all counters=0, synchronizer=2'b11, data=0, valid=0, frame_err=0, busy=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no valid or frame_err pulse; reception resumes on the next falling edge after release.

Structure
REQ-027 Package uart_pkg SHALL hold the state enum typedef, the DATA_BITS/OVERSAMPLE defaults, and the CLK_FREQ=100_000_000 constant.
REQ-028 Tick generation SHALL be a sub-module baud_tick_gen (CLK100MHZ, reset, count_lim -> tick); the FSM lives in uart_rx.

Verification
REQ-029 count_lim=54 (bit period 864 cycles), frame 0xA5 with stop=1 -> exactly one valid pulse, data=0xA5, frame_err=0.
REQ-030 rx low for 200 cycles then high (glitch shorter than half a bit, count_lim=54) -> no valid, no frame_err, FSM back to IDLE, busy low.
REQ-031 Frame 0x3C with stop bit low, line then held low for 5000 cycles -> one frame_err pulse, data keeps its prior value, busy high until rx returns high.
REQ-032 Frames 0x00, 0xFF, 0x55 back-to-back with no idle gap -> three valid pulses with the matching data, in order.
REQ-033 reset pulse at data bit 4 of frame 0x81, then a clean frame 0x7E -> no output for the aborted frame, then valid with data=0x7E.
REQ-034 count_lim=0 and count_lim=1 with a bit period of 16 cycles, frame 0xC3 -> valid with data=0xC3 in both cases.
